i2s_tx_wb_buffer: RTL and testbench
===================================

I2S_TX_WB_BUFFER -- requirements
Module: i2s_tx_wb_buffer

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_WIDTH, 16, sample width
- ADDR_WIDTH, 15, the buffer holds 2**(ADDR_WIDTH-1) samples
REQ-002 SHALL have ports, one per line:
- wb_clk  in  1  single clock
- wb_rst_n  in  1  reset, asynchronous, active-low
- wb_adr_i  in  16  word address; bit15=0 buffer (bits 13:0 index), bit15=1 registers (bits 1:0 offset)
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_we_i  in  1  write strobe
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_ack_o  out  1  acknowledge
- wb_int_o  out  1  interrupt, level
- sample_addr  in  14  codec read index
- mem_rdwr  in  1  codec read request
- sample_dat_o  out  DATA_WIDTH  sample to the codec
- evt_lsbf  in  1  codec finished the low half (pulse)
- evt_hsbf  in  1  codec finished the high half (pulse)
- conf_en  out  1  codec enable
- conf_swap  out  1  channel select
- conf_res  out  6  resolution
- conf_ratio  out  24  SCK divider

Function
REQ-003 Registers SHALL be:
- CTRL (offset 0): [0] en, [1] swap, [7:2] res, [8] lsbf_ie, [9] hsbf_ie.
- RATIO (offset 1): [23:0].
- STATUS (offset 2): [0] lsbf_pend, [1] hsbf_pend, [2] underrun; write-1-to-clear.
- Offset 3 SHALL be reserved and read 0.
REQ-004 conf_* outputs SHALL be driven directly from CTRL/RATIO flops; a write is visible the cycle after ack.
REQ-005 Bus protocol:
- wb_ack_o SHALL pulse high exactly one cycle, the cycle after stb&cyc is first sampled high.
- No ack SHALL be issued in the cycle following an ack; a held strobe yields one ack per two cycles.
REQ-006 Buffer write: wb_dat_i[DATA_WIDTH-1:0] SHALL be written to mem[wb_adr_i[13:0]] on the accepted cycle.
REQ-007 Buffer read: wb_dat_o SHALL carry the zero-extended word together with ack (one-cycle registered read).
REQ-008 Codec read: mem_rdwr high in cycle N SHALL load sample_dat_o with mem[sample_addr] at N+1; sample_dat_o SHALL hold until the next mem_rdwr.
REQ-009 A same-address host write and codec read in one cycle SHALL return the old data to the codec (read-before-write).
REQ-010 evt_lsbf SHALL set lsbf_pend and evt_hsbf SHALL set hsbf_pend; when a set and a W1C clear of the same bit coincide, the set SHALL win.
REQ-011 wb_int_o SHALL equal (lsbf_pend&lsbf_ie)|(hsbf_pend&hsbf_ie)|underrun, registered.
REQ-012 A write clearing CTRL.en SHALL also clear all STATUS bits in the same cycle.
REQ-013 Writes to reserved or unused bits SHALL be ignored; those bits SHALL read 0.

Reset
REQ-014 On wb_rst_n low, the following SHALL be 0 asynchronously: all registers, wb_ack_o, wb_int_o, sample_dat_o, all conf_* outputs.
REQ-015 Buffer contents SHALL NOT be reset.
REQ-016 A bus transfer in flight during reset SHALL be dropped; no ack SHALL be produced after reset release for that transfer.

Configuration
REQ-017 With macro I2S_UNDERRUN_DET_EN defined:
- evt_lsbf arriving while lsbf_pend is still 1, or evt_hsbf arriving while hsbf_pend is still 1, SHALL set STATUS.underrun (sticky, W1C).
REQ-018 Without I2S_UNDERRUN_DET_EN:
- STATUS[2] SHALL read 0 and SHALL never contribute to wb_int_o.
- No detection logic SHALL be present.

Structure
REQ-019 Package i2s_pkg SHALL hold:
- register offsets and CTRL/STATUS bit positions
- CONF_RES_W=6 and CONF_RATIO_W=24
REQ-020 The storage SHALL be a sub-module i2s_sample_ram:
- one read/write port for the host and one read-only port for the codec, both synchronous;
- everything else stays in the top module.

Verification
REQ-021 Bench SHALL cover:
- Write CTRL=0x0000_0041 (en=1, res=16) and RATIO=0x10 -> conf_en=1, conf_res=16, conf_ratio=0x10 one cycle after the respective ack; each ack lasts 1 cycle.
- Write 0xBEEF at index 5; drive sample_addr=5 with mem_rdwr pulse -> sample_dat_o=0xBEEF the next cycle, held after mem_rdwr drops.
- Write 0x1111 at index 7 and codec read of 7 in the same cycle (old 0x0000) -> sample_dat_o=0x0000; a subsequent codec read returns 0x1111.
- lsbf_ie=1, pulse evt_lsbf -> STATUS=0x1 and wb_int_o=1; W1C 0x1 coinciding with a new evt_lsbf -> bit stays 1.
- With I2S_UNDERRUN_DET_EN: two evt_hsbf pulses without a clear -> STATUS=0x6 and wb_int_o=1; without the macro -> STATUS=0x2.
- Assert wb_rst_n low mid-transfer -> wb_ack_o, conf_en, and sample_dat_o read 0 immediately; no ack after release.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: register map, bit positions and field widths for the I2S TX buffer
package i2s_pkg;
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_RATIO  = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_SWAP    = 1;
    localparam int CTRL_RES_LSB = 2;
    localparam int CTRL_LSBF_IE = 8;
    localparam int CTRL_HSBF_IE = 9;

    localparam int ST_LSBF     = 0;
    localparam int ST_HSBF     = 1;
    localparam int ST_UNDERRUN = 2;

    localparam int CONF_RES_W   = 6;
    localparam int CONF_RATIO_W = 24;
endpackage

// File: rtl/i2s_sample_ram.sv
// i2s_sample_ram: sample store with a host read/write port and a codec read-only port
module i2s_sample_ram #(
    parameter int DW = 16,
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          h_en,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic [DW-1:0] h_rdata,
    input  logic          c_en,
    input  logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (h_en && h_we) mem[h_addr] <= h_wdata;
        if (h_en) h_rdata <= mem[h_addr];
    end

    // the array itself is never reset; only the codec-facing output register is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) c_rdata <= '0;
        else if (c_en) c_rdata <= mem[c_addr];
    end
endmodule

// File: rtl/i2s_tx_wb_buffer.sv
// i2s_tx_wb_buffer: Wishbone sample buffer and control registers for an I2S transmitter; I2S_UNDERRUN_DET_EN enables underrun detection
module i2s_tx_wb_buffer
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    input  logic [15:0]             wb_adr_i,
    input  logic [31:0]             wb_dat_i,
    output logic [31:0]             wb_dat_o,
    input  logic                    wb_we_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    output logic                    wb_ack_o,
    output logic                    wb_int_o,
    input  logic [ADDR_WIDTH-2:0]   sample_addr,
    input  logic                    mem_rdwr,
    output logic [DATA_WIDTH-1:0]   sample_dat_o,
    input  logic                    evt_lsbf,
    input  logic                    evt_hsbf,
    output logic                    conf_en,
    output logic                    conf_swap,
    output logic [CONF_RES_W-1:0]   conf_res,
    output logic [CONF_RATIO_W-1:0] conf_ratio
);
    logic                    req, idle_seen, sel_buf, is_reg, wr_reg, en_clr;
    logic [1:0]              off;
    logic [2:0]              clr;
    logic                    lsbf_ie, hsbf_ie, lsbf_pend, hsbf_pend, underrun;
    logic [31:0]             reg_rd, reg_q;
    logic [DATA_WIDTH-1:0]   buf_q;
    logic                    unused_ok;

    // idle_seen drops any transfer still being strobed across a reset release
    assign req    = wb_stb_i & wb_cyc_i & ~wb_ack_o & idle_seen;
    assign is_reg = wb_adr_i[15];
    assign off    = wb_adr_i[1:0];
    assign wr_reg = req & is_reg & wb_we_i;
    assign clr    = (wr_reg && off == OFF_STATUS) ? wb_dat_i[2:0] : 3'b0;
    assign en_clr = wr_reg && off == OFF_CTRL && !wb_dat_i[CTRL_EN];

    assign unused_ok = &{1'b0, wb_dat_i[31:24], wb_adr_i[14], clr[ST_UNDERRUN]};

    always_comb begin
        reg_rd = off == OFF_CTRL   ? 32'({hsbf_ie, lsbf_ie, conf_res, conf_swap, conf_en}) :
                 off == OFF_RATIO  ? 32'(conf_ratio) :
                 off == OFF_STATUS ? 32'({underrun, hsbf_pend, lsbf_pend}) : 32'd0;
    end

    assign wb_dat_o = sel_buf ? 32'(buf_q) : reg_q;

    i2s_sample_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH-1)) u_ram (
        .clk     (wb_clk),
        .rst_n   (wb_rst_n),
        .h_en    (req & ~is_reg),
        .h_we    (wb_we_i),
        .h_addr  (wb_adr_i[ADDR_WIDTH-2:0]),
        .h_wdata (wb_dat_i[DATA_WIDTH-1:0]),
        .h_rdata (buf_q),
        .c_en    (mem_rdwr),
        .c_addr  (sample_addr),
        .c_rdata (sample_dat_o)
    );

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wb_ack_o  <= 1'b0;
            idle_seen <= 1'b0;
            sel_buf   <= 1'b0;
            reg_q     <= '0;
            wb_int_o  <= 1'b0;
        end else begin
            idle_seen <= idle_seen | ~(wb_stb_i & wb_cyc_i);
            wb_ack_o  <= req;
            if (req) begin
                sel_buf <= ~is_reg;
                reg_q   <= reg_rd;
            end
            wb_int_o  <= (lsbf_pend & lsbf_ie) | (hsbf_pend & hsbf_ie) | underrun;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            conf_en    <= 1'b0;
            conf_swap  <= 1'b0;
            conf_res   <= '0;
            lsbf_ie    <= 1'b0;
            hsbf_ie    <= 1'b0;
            conf_ratio <= '0;
            lsbf_pend  <= 1'b0;
            hsbf_pend  <= 1'b0;
        end else begin
            if (wr_reg && off == OFF_CTRL) begin
                conf_en   <= wb_dat_i[CTRL_EN];
                conf_swap <= wb_dat_i[CTRL_SWAP];
                conf_res  <= wb_dat_i[CTRL_RES_LSB +: CONF_RES_W];
                lsbf_ie   <= wb_dat_i[CTRL_LSBF_IE];
                hsbf_ie   <= wb_dat_i[CTRL_HSBF_IE];
            end
            if (wr_reg && off == OFF_RATIO) conf_ratio <= wb_dat_i[CONF_RATIO_W-1:0];
            // a new event beats a W1C of the same bit; disabling beats both
            lsbf_pend <= !en_clr && (evt_lsbf || (lsbf_pend && !clr[ST_LSBF]));
            hsbf_pend <= !en_clr && (evt_hsbf || (hsbf_pend && !clr[ST_HSBF]));
        end
    end

`ifdef I2S_UNDERRUN_DET_EN
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) underrun <= 1'b0;
        else underrun <= !en_clr && ((evt_lsbf && lsbf_pend) || (evt_hsbf && hsbf_pend) ||
                                     (underrun && !clr[ST_UNDERRUN]));
    end
`else
    assign underrun = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_tx_wb_buffer.sv
// tb_i2s_tx_wb_buffer: scoreboard bench for the I2S TX Wishbone buffer
module tb_i2s_tx_wb_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] adr = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
    logic        ack, irq;
    logic [13:0] sample_addr = '0;
    logic        mem_rdwr = 1'b0;
    logic [15:0] sample_dat;
    logic        evt_l = 1'b0, evt_h = 1'b0;
    logic        conf_en, conf_swap;
    logic [5:0]  conf_res;
    logic [23:0] conf_ratio;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];
    logic [15:0] cdc_q[$];

`ifdef I2S_UNDERRUN_DET_EN
    localparam logic [31:0] UR_STATUS = 32'h6;
    localparam logic        UR_IRQ    = 1'b1;
`else
    localparam logic [31:0] UR_STATUS = 32'h2;
    localparam logic        UR_IRQ    = 1'b0;
`endif

    always #5 clk = ~clk;

    i2s_tx_wb_buffer dut (
        .wb_clk       (clk),
        .wb_rst_n     (rst_n),
        .wb_adr_i     (adr),
        .wb_dat_i     (dat_i),
        .wb_dat_o     (dat_o),
        .wb_we_i      (we),
        .wb_stb_i     (stb),
        .wb_cyc_i     (cyc),
        .wb_ack_o     (ack),
        .wb_int_o     (irq),
        .sample_addr  (sample_addr),
        .mem_rdwr     (mem_rdwr),
        .sample_dat_o (sample_dat),
        .evt_lsbf     (evt_l),
        .evt_hsbf     (evt_h),
        .conf_en      (conf_en),
        .conf_swap    (conf_swap),
        .conf_res     (conf_res),
        .conf_ratio   (conf_ratio)
    );

    // called at a negedge; returns at the negedge after the ack cycle
    task automatic wb_cycle(input logic [15:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] q, output int lat, output logic tail);
        lat = 0;
        adr = a; dat_i = d; we = w; stb = 1'b1; cyc = 1'b1;
        do begin @(negedge clk); lat++; end while (!ack && lat < 8);
        q = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!ack) begin
            compared++; mismatched++;
            $display("FAIL bus_timeout adr=%h: no ack within %0d cycles", a, lat);
        end
        @(negedge clk);
        tail = ack;
    endtask

    task automatic codec_pulse(input logic [13:0] a);
        sample_addr = a; mem_rdwr = 1'b1;
        @(negedge clk);
        mem_rdwr = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({ack, irq, conf_en, conf_swap, conf_res, conf_ratio, sample_dat} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs got ack=%b int=%b en=%b swap=%b res=%h ratio=%h smp=%h want all 0",
                     ack, irq, conf_en, conf_swap, conf_res, conf_ratio, sample_dat);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ctrl;
        logic [31:0] q, e; int lat; logic tail;
        wb_cycle(16'h8000, 1'b1, 32'h0000_0041, q, lat, tail);
        compared++; if (lat !== 1) begin mismatched++; $display("FAIL ctrl_ack_latency got %0d want 1", lat); end
        compared++; if (tail !== 1'b0) begin mismatched++; $display("FAIL ctrl_ack_width got ack=%b want 0", tail); end
        compared++;
        if (conf_en !== 1'b1 || conf_res !== 6'd16 || conf_swap !== 1'b0) begin
            mismatched++; $display("FAIL conf_ctrl got en=%b res=%0d swap=%b want 1/16/0", conf_en, conf_res, conf_swap);
        end
        wb_cycle(16'h8001, 1'b1, 32'h0000_0010, q, lat, tail);
        compared++; if (tail !== 1'b0) begin mismatched++; $display("FAIL ratio_ack_width got ack=%b want 0", tail); end
        compared++; if (conf_ratio !== 24'h10) begin mismatched++; $display("FAIL conf_ratio got %h want 000010", conf_ratio); end
        exp_q.push_back(32'h41);
        exp_q.push_back(32'h10);
        for (int i = 0; i < 2; i++) begin
            wb_cycle(16'h8000 + 16'(i), 1'b0, 32'h0, q, lat, tail);
            e = exp_q.pop_front();
            compared++; if (q !== e) begin mismatched++; $display("FAIL reg_read[%0d] got %h want %h", i, q, e); end
        end
    endtask

    task automatic test_reserved;
        logic [31:0] q, e; int lat; logic tail;
        wb_cycle(16'h8003, 1'b1, 32'hFFFF_FFFF, q, lat, tail);
        wb_cycle(16'h8000, 1'b1, 32'hFFFF_FFFE, q, lat, tail);
        wb_cycle(16'h8001, 1'b1, 32'hFFFF_FFFF, q, lat, tail);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h3FE);
        exp_q.push_back(32'h00FF_FFFF);
        foreach (exp_q[i]) begin end
        for (int i = 0; i < 3; i++) begin
            wb_cycle(i == 0 ? 16'h8003 : 16'h8000 + 16'(i - 1), 1'b0, 32'h0, q, lat, tail);
            e = exp_q.pop_front();
            compared++; if (q !== e) begin mismatched++; $display("FAIL unused_bits[%0d] got %h want %h", i, q, e); end
        end
        wb_cycle(16'h8000, 1'b1, 32'h0000_0041, q, lat, tail);
        wb_cycle(16'h8001, 1'b1, 32'h0000_0010, q, lat, tail);
    endtask

    task automatic test_buffer;
        logic [31:0] q, e; int lat; logic tail; logic [15:0] c;
        wb_cycle(16'h0005, 1'b1, 32'hABCD_BEEF, q, lat, tail);
        cdc_q.push_back(16'hBEEF);
        codec_pulse(14'd5);
        c = cdc_q.pop_front();
        compared++; if (sample_dat !== c) begin mismatched++; $display("FAIL codec_read5 got %h want %h", sample_dat, c); end
        sample_addr = 14'd9;
        repeat (2) @(negedge clk);
        compared++; if (sample_dat !== c) begin mismatched++; $display("FAIL codec_hold got %h want %h", sample_dat, c); end
        exp_q.push_back(32'h0000_BEEF);
        wb_cycle(16'h0005, 1'b0, 32'h0, q, lat, tail);
        e = exp_q.pop_front();
        compared++; if (q !== e) begin mismatched++; $display("FAIL buf_read5 got %h want %h", q, e); end
    endtask

    task automatic test_read_before_write;
        logic [31:0] q; int lat; logic tail; logic [15:0] c;
        wb_cycle(16'h0007, 1'b1, 32'h0, q, lat, tail);
        cdc_q.push_back(16'h0000);
        cdc_q.push_back(16'h1111);
        adr = 16'h0007; dat_i = 32'h1111; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        sample_addr = 14'd7; mem_rdwr = 1'b1;
        @(negedge clk);
        mem_rdwr = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        compared++; if (ack !== 1'b1) begin mismatched++; $display("FAIL rbw_ack got %b want 1", ack); end
        c = cdc_q.pop_front();
        compared++; if (sample_dat !== c) begin mismatched++; $display("FAIL rbw_old got %h want %h", sample_dat, c); end
        @(negedge clk);
        codec_pulse(14'd7);
        c = cdc_q.pop_front();
        compared++; if (sample_dat !== c) begin mismatched++; $display("FAIL rbw_new got %h want %h", sample_dat, c); end
    endtask

    task automatic test_held_strobe;
        logic [31:0] q, e; int lat; logic tail; int acks;
        acks = 0;
        adr = 16'h0009; dat_i = 32'h2222; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        repeat (4) begin @(negedge clk); acks += int'(ack); end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        compared++; if (acks !== 2) begin mismatched++; $display("FAIL held_strobe_acks got %0d want 2", acks); end
        exp_q.push_back(32'h2222);
        wb_cycle(16'h0009, 1'b0, 32'h0, q, lat, tail);
        e = exp_q.pop_front();
        compared++; if (q !== e) begin mismatched++; $display("FAIL held_strobe_data got %h want %h", q, e); end
    endtask

    task automatic test_irq;
        logic [31:0] q, e; int lat; logic tail;
        wb_cycle(16'h8000, 1'b1, 32'h0000_0141, q, lat, tail);
        evt_l = 1'b1; @(negedge clk); evt_l = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (irq !== 1'b1) begin mismatched++; $display("FAIL lsbf_int got %b want 1", irq); end
        exp_q.push_back(32'h1);
        wb_cycle(16'h8002, 1'b0, 32'h0, q, lat, tail);
        e = exp_q.pop_front();
        compared++; if (q !== e) begin mismatched++; $display("FAIL lsbf_status got %h want %h", q, e); end
        adr = 16'h8002; dat_i = 32'h1; we = 1'b1; stb = 1'b1; cyc = 1'b1; evt_l = 1'b1;
        @(negedge clk);
        evt_l = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        exp_q.push_back(32'h1);
        wb_cycle(16'h8002, 1'b0, 32'h0, q, lat, tail);
        e = exp_q.pop_front();
        compared++; if (q !== e) begin mismatched++; $display("FAIL set_beats_w1c got %h want %h", q, e); end
        wb_cycle(16'h8002, 1'b1, 32'h1, q, lat, tail);
        repeat (2) @(negedge clk);
        compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL w1c_int got %b want 0", irq); end
    endtask

    task automatic test_underrun;
        logic [31:0] q, e; int lat; logic tail;
        evt_h = 1'b1; @(negedge clk); evt_h = 1'b0;
        @(negedge clk);
        evt_h = 1'b1; @(negedge clk); evt_h = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (irq !== UR_IRQ) begin mismatched++; $display("FAIL underrun_int got %b want %b", irq, UR_IRQ); end
        exp_q.push_back(UR_STATUS);
        wb_cycle(16'h8002, 1'b0, 32'h0, q, lat, tail);
        e = exp_q.pop_front();
        compared++; if (q !== e) begin mismatched++; $display("FAIL underrun_status got %h want %h", q, e); end
        wb_cycle(16'h8000, 1'b1, 32'h0, q, lat, tail);
        exp_q.push_back(32'h0);
        wb_cycle(16'h8002, 1'b0, 32'h0, q, lat, tail);
        e = exp_q.pop_front();
        compared++; if (q !== e) begin mismatched++; $display("FAIL disable_clears_status got %h want %h", q, e); end
        wb_cycle(16'h8000, 1'b1, 32'h0000_0041, q, lat, tail);
    endtask

    task automatic test_reset_midflight;
        logic [31:0] q, e; int lat; logic tail; int acks; logic [15:0] c;
        codec_pulse(14'd7);
        @(negedge clk);
        adr = 16'h8001; dat_i = 32'h55; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        compared++;
        if (ack !== 1'b0 || conf_en !== 1'b0 || sample_dat !== 16'h0) begin
            mismatched++; $display("FAIL async_reset got ack=%b en=%b smp=%h want 0/0/0000", ack, conf_en, sample_dat);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (4) begin @(negedge clk); acks += int'(ack); end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        compared++; if (acks !== 0) begin mismatched++; $display("FAIL ack_after_reset got %0d want 0", acks); end
        exp_q.push_back(32'h0);
        wb_cycle(16'h8001, 1'b0, 32'h0, q, lat, tail);
        e = exp_q.pop_front();
        compared++; if (q !== e) begin mismatched++; $display("FAIL ratio_after_reset got %h want %h", q, e); end
        cdc_q.push_back(16'hBEEF);
        codec_pulse(14'd5);
        c = cdc_q.pop_front();
        compared++; if (sample_dat !== c) begin mismatched++; $display("FAIL buffer_kept got %h want %h", sample_dat, c); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_ctrl;
        test_reserved;
        test_buffer;
        test_read_before_write;
        test_held_strobe;
        test_irq;
        test_underrun;
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
